sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single off-chip 16-bit SRAM port between two requesters: the processor core and the JTAG debug engine.
- Each access is sequenced as setup, then access, then done. The block drives SRAM address, data-out enable, write and chip-enable, and returns read data plus a one-cycle ack to the winning requester.
- Sits inside the microprocessor, between the core/debug logic and the SRAM pins. The chassis gates the write strobe with the clock externally.

Parameters:
- ADDR_W, 16, SRAM word-address width
- DATA_W, 16, SRAM data width
- ACCESS_CYCLES, 2, cycles spent in ACCESS per transfer; must be at least 1 (elaboration error otherwise)

Ports:
- arb_clk  in  1  system clock; one clock domain, the only clock
- arb_rst  in  1  synchronous, active-high reset
- arb_coreReq_i  in  1  core request level
- arb_coreWr_i  in  1  core op: 1 = write, 0 = read
- arb_coreAddr_i  in  ADDR_W  core address
- arb_coreWdata_i  in  DATA_W  core write data
- arb_coreAck_o  out  1  core completion pulse
- arb_coreRdata_o  out  DATA_W  core read data
- arb_dbgReq_i / arb_dbgWr_i / arb_dbgAddr_i / arb_dbgWdata_i  in  1/1/ADDR_W/DATA_W  debug request set
- arb_dbgAck_o  out  1  debug completion pulse
- arb_dbgRdata_o  out  DATA_W  debug read data
- arb_dbgLock_i  in  1  debug exclusive mode; core is never granted while this is high
- arb_sramAddr_o  out  ADDR_W  SRAM address
- arb_sramWdata_o  out  DATA_W  SRAM write data
- arb_sramRdata_i  in  DATA_W  SRAM read data (from the tri-state pad)
- arb_sramDrive_o  out  1  pad output enable
- arb_sramWr_o  out  1  write strobe, active-high
- arb_sramEn_o  out  1  chip enable, active-high
- arb_owner_o  out  1  current or last owner: 0 = core, 1 = debug
- arb_busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, cycle counter 0, lastOwner = debug (so the core wins the first tie). An access in flight when reset asserts is aborted with no ack.
- IDLE:
  - Requests are sampled only in this state.
  - Winner selection: if dbgLock is high, debug wins if requesting; otherwise nothing is granted.
  - Else, a single requester wins.
  - Else, when both request, the side other than lastOwner wins (round-robin).
  - On grant: latch addr, wdata, wr and owner; set lastOwner to the winner; go to SETUP.
- SETUP (1 cycle):
  - sramEn = 1, addr valid, sramWr = 0.
  - sramDrive = latched wr; data is stable before the strobe.
  - Counter loaded with ACCESS_CYCLES-1.
- ACCESS (ACCESS_CYCLES cycles):
  - sramEn = 1; sramWr = latched wr; drive is held.
  - Counter decrements each cycle.
  - On the counter-zero cycle: a read captures arb_sramRdata_i into the owner's Rdata register at the clock edge; then go to DONE.
- DONE (1 cycle):
  - sramEn, sramWr and sramDrive = 0; address is held.
  - Owner's ack = 1 for exactly this cycle; the other ack stays 0.
  - Go to IDLE.
- Latency: request high in IDLE at cycle N gives ack at cycle N+2+ACCESS_CYCLES. Minimum spacing between back-to-back grants is ACCESS_CYCLES+3 cycles.
- Handshake rules:
  - A requester holds req, addr, wdata and wr stable until it sees ack, then drops req at that same clock edge.
  - If req is still high in the following IDLE cycle, it is a new request.
  - Inputs changing after the grant have no effect.
- Read data persistence: each Rdata register holds its value until that requester's next completed read. Writes do not alter it.
- Edge cases:
  - Request dropped between grant and DONE: the access still completes and ack is still pulsed.
  - dbgLock rising mid-access: the current access completes; the lock applies from the next IDLE.
  - Both requests simultaneous with dbgLock low: strict alternation while both persist.
  - Address wrap is not applicable; the address passes through unchanged.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, DONE}
  - owner enum {OWN_CORE=0, OWN_DBG=1}
  - default ADDR_W and DATA_W constants
- One sub-module, sram_arb_rr: combinational 2-way round-robin picker with lock override.
  - Inputs: reqs, lock, lastOwner.
  - Outputs: grant valid, winner.

Test Plan (ACCESS_CYCLES=2):
- Core read 0x0010, SRAM model returns 0xBEEF → sramEn high for cycles N+1..N+3, sramWr never high, coreAck at N+4 only, coreRdata=0xBEEF, dbgAck stays 0.
- Debug write 0x1234 to 0x00FF → SETUP with drive=1, wr=0; wr=1 for exactly 2 cycles; dbgAck at N+4; a model read-back of 0x00FF returns 0x1234; dbgRdata unchanged.
- Both request continuously from reset → grants alternate core, dbg, core, dbg; acks 5 cycles apart, first at N+4.
- dbgLock=1 with both requesting for 20 cycles → only dbgAck pulses, coreAck stays 0. Drop the lock → the next grant goes to the core.
- Assert arb_rst during ACCESS of a write → next cycle all outputs 0, no ack issued, state IDLE, busy=0.
- Core read completes, then core writes 0xAAAA → coreRdata retains the read value. Core request dropped mid-access → ack still pulses once.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-requester SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDataW = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

endpackage

// File: rtl/sram_arb_rr.sv
// Combinational 2-way round-robin picker; lock hands the port exclusively to debug.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic [1:0] reqs_i,        // bit 0 = core, bit 1 = debug
    input  logic       lock_i,
    input  owner_e     last_owner_i,
    output logic       valid_o,
    output owner_e     winner_o
);

    always_comb begin
        valid_o  = 1'b0;
        winner_o = OWN_CORE;
        if (lock_i) begin
            valid_o  = reqs_i[1];
            winner_o = OWN_DBG;
        end else begin
            unique case (reqs_i)
                2'b01: begin
                    valid_o  = 1'b1;
                    winner_o = OWN_CORE;
                end
                2'b10: begin
                    valid_o  = 1'b1;
                    winner_o = OWN_DBG;
                end
                2'b11: begin
                    valid_o  = 1'b1;
                    winner_o = (last_owner_i == OWN_CORE) ? OWN_DBG : OWN_CORE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM port between core and debug: IDLE -> SETUP -> ACCESS x N -> DONE per access.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = DefAddrW,
    parameter int unsigned DATA_W        = DefDataW,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic              arb_clk,
    input  logic              arb_rst,
    input  logic              arb_coreReq_i,
    input  logic              arb_coreWr_i,
    input  logic [ADDR_W-1:0] arb_coreAddr_i,
    input  logic [DATA_W-1:0] arb_coreWdata_i,
    output logic              arb_coreAck_o,
    output logic [DATA_W-1:0] arb_coreRdata_o,
    input  logic              arb_dbgReq_i,
    input  logic              arb_dbgWr_i,
    input  logic [ADDR_W-1:0] arb_dbgAddr_i,
    input  logic [DATA_W-1:0] arb_dbgWdata_i,
    output logic              arb_dbgAck_o,
    output logic [DATA_W-1:0] arb_dbgRdata_o,
    input  logic              arb_dbgLock_i,
    output logic [ADDR_W-1:0] arb_sramAddr_o,
    output logic [DATA_W-1:0] arb_sramWdata_o,
    input  logic [DATA_W-1:0] arb_sramRdata_i,
    output logic              arb_sramDrive_o,
    output logic              arb_sramWr_o,
    output logic              arb_sramEn_o,
    output logic              arb_owner_o,
    output logic              arb_busy_o
);

    if (ACCESS_CYCLES < 1) begin : g_bad_cfg
        $error("sram_arbiter: ACCESS_CYCLES must be at least 1");
    end

    localparam int unsigned     CntW    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(ACCESS_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic   grant_valid;
    owner_e winner;

    sram_arb_rr u_rr (
        .reqs_i       ({arb_dbgReq_i, arb_coreReq_i}),
        .lock_i       (arb_dbgLock_i),
        .last_owner_i (last_q),
        .valid_o      (grant_valid),
        .winner_o     (winner)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        owner_d      = owner_q;
        last_d       = last_q;
        core_rdata_d = core_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = SETUP;
                    owner_d = winner;
                    last_d  = winner;
                    if (winner == OWN_DBG) begin
                        addr_d  = arb_dbgAddr_i;
                        wdata_d = arb_dbgWdata_i;
                        wr_d    = arb_dbgWr_i;
                    end else begin
                        addr_d  = arb_coreAddr_i;
                        wdata_d = arb_coreWdata_i;
                        wr_d    = arb_coreWr_i;
                    end
                end
            end
            SETUP: begin
                cnt_d   = CntLoad;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    // Read data is taken on the last access edge, while the SRAM is still enabled.
                    if (!wr_q) begin
                        if (owner_q == OWN_DBG) dbg_rdata_d  = arb_sramRdata_i;
                        else                    core_rdata_d = arb_sramRdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            owner_q      <= OWN_CORE;
            last_q       <= OWN_DBG;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            core_rdata_q <= core_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    logic in_xfer;
    assign in_xfer = (state_q == SETUP) || (state_q == ACCESS);

    assign arb_sramAddr_o  = addr_q;
    assign arb_sramWdata_o = wdata_q;
    assign arb_sramEn_o    = in_xfer;
    assign arb_sramDrive_o = in_xfer && wr_q;
    assign arb_sramWr_o    = (state_q == ACCESS) && wr_q;
    assign arb_coreAck_o   = (state_q == DONE) && (owner_q == OWN_CORE);
    assign arb_dbgAck_o    = (state_q == DONE) && (owner_q == OWN_DBG);
    assign arb_coreRdata_o = core_rdata_q;
    assign arb_dbgRdata_o  = dbg_rdata_q;
    assign arb_owner_o     = owner_q;
    assign arb_busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench: a transaction-timeline model of the arbiter plus a behavioural SRAM.
module tb_sram_arbiter;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int          AC   = 2;
    localparam int          NCyc = 3000;
    localparam int          SFree = 0, SWait = 1, SGrant = 2, SDrop = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_wr, dbg_req, dbg_wr, lock;
    logic [AW-1:0] core_addr, dbg_addr, sram_addr;
    logic [DW-1:0] core_wdata, dbg_wdata, sram_wdata, sram_rdata, core_rdata, dbg_rdata;
    logic          core_ack, dbg_ack, sram_drive, sram_wr, sram_en, owner, busy;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .ACCESS_CYCLES (AC)
    ) dut (
        .arb_clk         (clk),
        .arb_rst         (rst),
        .arb_coreReq_i   (core_req),
        .arb_coreWr_i    (core_wr),
        .arb_coreAddr_i  (core_addr),
        .arb_coreWdata_i (core_wdata),
        .arb_coreAck_o   (core_ack),
        .arb_coreRdata_o (core_rdata),
        .arb_dbgReq_i    (dbg_req),
        .arb_dbgWr_i     (dbg_wr),
        .arb_dbgAddr_i   (dbg_addr),
        .arb_dbgWdata_i  (dbg_wdata),
        .arb_dbgAck_o    (dbg_ack),
        .arb_dbgRdata_o  (dbg_rdata),
        .arb_dbgLock_i   (lock),
        .arb_sramAddr_o  (sram_addr),
        .arb_sramWdata_o (sram_wdata),
        .arb_sramRdata_i (sram_rdata),
        .arb_sramDrive_o (sram_drive),
        .arb_sramWr_o    (sram_wr),
        .arb_sramEn_o    (sram_en),
        .arb_owner_o     (owner),
        .arb_busy_o      (busy)
    );

    // Behavioural SRAM: 256 words, aliased on the low address byte.
    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        return {a, ~a} ^ 16'h3C5A;
    endfunction

    logic [DW-1:0] env_mem [256];
    bit            env_vld [256];

    always @(posedge clk) begin
        if (sram_wr && sram_drive) begin
            env_mem[sram_addr[7:0]] <= sram_wdata;
            env_vld[sram_addr[7:0]] <= 1'b1;
        end
    end

    assign sram_rdata = (sram_en && !sram_drive) ?
        (env_vld[sram_addr[7:0]] ? env_mem[sram_addr[7:0]] : init_val(sram_addr[7:0])) : '0;

    // Reference memory and requester state.
    logic [DW-1:0] ref_mem [256];
    bit            ref_vld [256];
    int            st [2];
    logic          rq [2];
    logic          rw [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];

    assign core_req   = rq[0];
    assign core_wr    = rw[0];
    assign core_addr  = ra[0];
    assign core_wdata = rd[0];
    assign dbg_req    = rq[1];
    assign dbg_wr     = rw[1];
    assign dbg_addr   = ra[1];
    assign dbg_wdata  = rd[1];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_vld[a[7:0]] ? ref_mem[a[7:0]] : init_val(a[7:0]);
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: one access occupies cycles g (grant in IDLE) .. g+AC+2 (DONE).
    bit            act;
    int            g, own, last, exp_owner, p, win, prob;
    logic          op_wr;
    logic [AW-1:0] op_a;
    logic [DW-1:0] op_d;
    logic [DW-1:0] exp_rd [2];
    bit            post_reset, done_now, rst_now, drop_en;

    task automatic model_reset();
        act       = 1'b0;
        last      = 1;
        exp_owner = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int s = 0; s < 2; s++) begin
            st[s] = SFree;
            rq[s] = 1'b0;
        end
    endtask

    initial begin
        rst  = 1'b1;
        lock = 1'b0;
        for (int s = 0; s < 2; s++) begin
            rw[s] = 1'b0;
            ra[s] = '0;
            rd[s] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b0;
        post_reset = 1'b1;

        for (int c = 0; c < NCyc; c++) begin
            // Expected outputs for cycle c.
            p = (act && c > g) ? c - g : 0;
            if (p == 1) exp_owner = own;
            if (p == AC + 2 && !op_wr) exp_rd[own] = ref_rd(op_a);
            check_eq("sramEn",    32'(sram_en),    32'(p >= 1 && p <= AC + 1));
            check_eq("sramWr",    32'(sram_wr),    32'(p >= 2 && p <= AC + 1 && op_wr));
            check_eq("sramDrive", 32'(sram_drive), 32'(p >= 1 && p <= AC + 1 && op_wr));
            check_eq("busy",      32'(busy),       32'(p >= 1));
            check_eq("coreAck",   32'(core_ack),   32'(p == AC + 2 && own == 0));
            check_eq("dbgAck",    32'(dbg_ack),    32'(p == AC + 2 && own == 1));
            check_eq("owner",     32'(owner),      32'(exp_owner));
            check_eq("coreRdata", 32'(core_rdata), 32'(exp_rd[0]));
            check_eq("dbgRdata",  32'(dbg_rdata),  32'(exp_rd[1]));
            if (p >= 1) check_eq("sramAddr", 32'(sram_addr), 32'(op_a));
            if (p >= 1 && p <= AC + 1 && op_wr) check_eq("sramWdata", 32'(sram_wdata), 32'(op_d));
            if (post_reset) begin
                check_eq("rstAddr",  32'(sram_addr),  32'h0);
                check_eq("rstWdata", 32'(sram_wdata), 32'h0);
                post_reset = 1'b0;
            end
            done_now = (p == AC + 2);
            if (done_now) begin
                if (op_wr) begin
                    ref_mem[op_a[7:0]] = op_d;
                    ref_vld[op_a[7:0]] = 1'b1;
                end
                act = 1'b0;
            end

            // Stimulus phases: both persistent, then locked, then fully random.
            if (c < 40) begin
                lock = 1'b0; prob = 100; drop_en = 1'b0;
            end else if (c < 80) begin
                lock = 1'b1; prob = 100; drop_en = 1'b0;
            end else begin
                if (c == 80) lock = 1'b0;
                else if ($urandom_range(0, 99) < 5) lock = ~lock;
                prob = 40; drop_en = 1'b1;
            end
            for (int s = 0; s < 2; s++) begin
                if (st[s] == SFree) begin
                    if ($urandom_range(0, 99) < prob) begin
                        rq[s] = 1'b1;
                        rw[s] = 1'($urandom);
                        ra[s] = {8'($urandom), 4'h0, 4'($urandom)};
                        rd[s] = 16'($urandom);
                        st[s] = SWait;
                    end else begin
                        rq[s] = 1'b0;
                    end
                end else if (st[s] == SGrant && drop_en && $urandom_range(0, 7) == 0) begin
                    rq[s] = 1'b0;
                    st[s] = SDrop;
                end
            end
            if (done_now) st[own] = SFree;

            // Occasionally abort a write mid-access; the strobe has already hit the SRAM.
            rst_now = (c >= 80) && act && op_wr && p >= 2 && p <= AC + 1 &&
                      ($urandom_range(0, 9) == 0);
            if (rst_now) begin
                rst = 1'b1;
                ref_mem[op_a[7:0]] = op_d;
                ref_vld[op_a[7:0]] = 1'b1;
                model_reset();
                post_reset = 1'b1;
            end else begin
                rst = 1'b0;
            end

            if (!rst_now && !act && !done_now) begin
                win = -1;
                if (lock)                win = rq[1] ? 1 : -1;
                else if (rq[0] && rq[1]) win = 1 - last;
                else if (rq[0])          win = 0;
                else if (rq[1])          win = 1;
                if (win >= 0) begin
                    act     = 1'b1;
                    g       = c;
                    own     = win;
                    op_wr   = rw[win];
                    op_a    = ra[win];
                    op_d    = rd[win];
                    last    = win;
                    st[win] = SGrant;
                end
            end

            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
